// File: rtl/pkg_rv32_types.sv
// Shared RV32 types: M-extension op encoding, MDU FSM states and divider sizing.
package pkg_rv32_types;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned MDU_DIV_CYCLES = 32;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    MduIdle,
    MduMul,
    MduDiv,
    MduDone
  } mdu_state_e;

  function automatic logic op_is_div(input m_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_signed_div(input m_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_is_rem(input m_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/rv32_mdu_divider.sv
// Sequential restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done_o flags the last iteration; quotient_o/remainder_o are that iteration's results.
module rv32_mdu_divider
  import pkg_rv32_types::*;
#(
  parameter int unsigned Cycles = MDU_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(Cycles);

  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [XLEN-1:0] quo_d, rem_d;
  logic [XLEN:0]   shifted, diff;
  logic            ge;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, div_q};
    ge      = shifted >= {1'b0, div_q};
    rem_d   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ge};
  end

  assign done_o      = busy_q && (cnt_q == CntW'(Cycles - 1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      div_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CntW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32_mdu.sv
// RV32 M-extension unit: single-cycle multiply, 32-cycle restoring divide,
// stalls the core while busy and pulses m_done with the registered result.
module rv32_mdu
  import pkg_rv32_types::*;
#(
  parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_valid,
  input  m_op_e           m_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            m_stall,
  output logic            m_done,
  output logic [XLEN-1:0] m_result
);

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q;
  m_op_e           op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;

  // Request decode in IDLE
  logic            req_signed, req_div_zero, req_ovf, req_special;
  logic [XLEN-1:0] special_res, abs_a, abs_b;

  always_comb begin
    req_signed   = op_is_signed_div(m_op);
    req_div_zero = (rs2_data == '0);
    req_ovf      = req_signed && (rs1_data == IntMin) && (rs2_data == '1);
    req_special  = op_is_div(m_op) && (req_div_zero || req_ovf);
    if (op_is_rem(m_op)) begin
      special_res = req_div_zero ? rs1_data : '0;
    end else begin
      special_res = req_div_zero ? '1 : IntMin;
    end
    abs_a = (req_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    abs_b = (req_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
  end

  // Multiplier: sign-extend to full product width so a plain multiply is exact mod 2^64.
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    a_sx    = (op_q == OpMul || op_q == OpMulh || op_q == OpMulhsu) && a_q[XLEN-1];
    b_sx    = (op_q == OpMul || op_q == OpMulh) && b_q[XLEN-1];
    a_w     = {{XLEN{a_sx}}, a_q};
    b_w     = {{XLEN{b_sx}}, b_q};
    prod    = a_w * b_w;
    mul_res = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Divider and sign fix on its final iteration
  logic            div_start, div_abort, div_done;
  logic [XLEN-1:0] div_quo, div_rem, div_res;
  logic            q_neg, r_neg;

  assign div_start = (state_q == MduIdle) && m_valid && op_is_div(m_op) && !req_special;
  assign div_abort = (state_q == MduDiv) && !m_valid;

  rv32_mdu_divider #(
    .Cycles (DIV_CYCLES)
  ) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .abort_i     (div_abort),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    q_neg = op_is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg = op_is_signed_div(op_q) && a_q[XLEN-1];
    if (op_is_rem(op_q)) begin
      div_res = r_neg ? -div_rem : div_rem;
    end else begin
      div_res = q_neg ? -div_quo : div_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MduIdle;
      op_q     <= OpMul;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        MduIdle: begin
          if (m_valid) begin
            op_q <= m_op;
            a_q  <= rs1_data;
            b_q  <= rs2_data;
            if (!op_is_div(m_op)) begin
              state_q <= MduMul;
            end else if (req_special) begin
              result_q <= special_res;
              state_q  <= MduDone;
            end else begin
              state_q <= MduDiv;
            end
          end
        end
        MduMul: begin
          if (!m_valid) begin
            state_q <= MduIdle;
          end else begin
            result_q <= mul_res;
            state_q  <= MduDone;
          end
        end
        MduDiv: begin
          if (!m_valid) begin
            state_q <= MduIdle;
          end else if (div_done) begin
            result_q <= div_res;
            state_q  <= MduDone;
          end
        end
        // m_valid still high here belongs to the finished instruction
        MduDone: state_q <= MduIdle;
        default: state_q <= MduIdle;
      endcase
    end
  end

  assign m_stall  = rst_n && m_valid && (state_q != MduDone);
  assign m_done   = (state_q == MduDone);
  assign m_result = result_q;

endmodule

// File: tb/tb_rv32_mdu.sv
// Scoreboard bench for rv32_mdu: driver pushes model results with expected done cycle,
// a negedge monitor pops and compares on every m_done pulse.
module tb_rv32_mdu;
  import pkg_rv32_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  m_op_e       m_op;
  logic [31:0] rs1_data, rs2_data;
  logic        m_stall, m_done;
  logic [31:0] m_result;

  rv32_mdu #(
    .DIV_CYCLES (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .m_op     (m_op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .m_stall  (m_stall),
    .m_done   (m_done),
    .m_result (m_result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned when;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the ISA definition using wide integer arithmetic.
  function automatic logic [31:0] model(input m_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OpMul:    begin sp = sa * sb; return sp[31:0]; end
      OpMulh:   begin sp = sa * sb; return sp[63:32]; end
      OpMulhsu: begin sp = sa * longint'(ub); return sp[63:32]; end
      OpMulhu:  begin up = ua * ub; return up[63:32]; end
      OpDiv: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      OpRem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      OpDivu: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int unsigned latency(input m_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (int'(op) < 4) return 2;
    if (b == 0) return 1;
    if ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every m_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got pulse with result %h, expected no pulse (cycle %0d)",
                 m_result, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, m_result, mon_e.res);
        check({mon_e.name, "_done_cycle"}, cyc, mon_e.when);
      end
    end
  end

  // Call #1 after a posedge with the DUT in IDLE; returns #1 after the posedge leaving DONE.
  task automatic run_op(input m_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit drop_after);
    int unsigned n, lat;
    bit          seen;
    exp_t        e;
    m_valid  = 1'b1;
    m_op     = op;
    rs1_data = a;
    rs2_data = b;
    n        = cyc;
    lat      = latency(op, a, b);
    e.res    = model(op, a, b);
    e.when   = n + lat;
    e.name   = op.name();
    sb_q.push_back(e);
    last_res = e.res;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      check({op.name(), "_stall"}, {31'b0, m_stall}, {31'b0, (cyc != n + lat)});
      if (m_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no m_done in 40 cycles, expected one at cycle %0d",
               op.name(), n + lat);
    end
    @(posedge clk);
    #1;
    if (drop_after) m_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    m_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_op     = OpMul;
    rs1_data = '0;
    rs2_data = '0;
    rst_n    = 1'b0;
    m_valid  = 1'b1;  // stall must stay low while in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'b0, m_stall}, 32'd0);
    check("reset_done", {31'b0, m_done}, 32'd0);
    check("reset_result", m_result, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_valid = 1'b0;
    idle_cycles(2);

    // Directed cases
    run_op(OpMul,    32'd7,         32'hFFFF_FFFD, 1'b1);
    run_op(OpMulh,   32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(OpDiv,    32'hFFFF_FFF9, 32'd2,         1'b1);
    run_op(OpRem,    32'hFFFF_FFF9, 32'd2,         1'b1);
    run_op(OpDivu,   32'd100,       32'd7,         1'b1);
    run_op(OpRemu,   32'd100,       32'd7,         1'b1);
    run_op(OpDivu,   32'd5,         32'd0,         1'b1);
    run_op(OpRemu,   32'd5,         32'd0,         1'b1);
    run_op(OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle_cycles(1);

    // Abort in DIV: no pulse, result held
    m_valid  = 1'b1;
    m_op     = OpDivu;
    rs1_data = 32'd1234;
    rs2_data = 32'd5;
    repeat (6) @(posedge clk);
    #1;
    m_valid = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("abort_div_result", m_result, last_res);

    // Abort in MUL
    m_valid  = 1'b1;
    m_op     = OpMul;
    rs1_data = 32'd3;
    rs2_data = 32'd3;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_mul_result", m_result, last_res);

    // Reset at N+10 of a DIVU
    m_valid  = 1'b1;
    m_op     = OpDivu;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_stall", {31'b0, m_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_valid = 1'b0;
    check("midreset_result", m_result, 32'd0);
    check("midreset_done", {31'b0, m_done}, 32'd0);
    last_res = '0;
    idle_cycles(40);
    run_op(OpDivu, 32'd9, 32'd3, 1'b1);
    idle_cycles(1);

    // Back-to-back with m_valid held high: pulses three cycles apart
    run_op(OpDivu, 32'd100, 32'd7, 1'b0);
    run_op(OpMul,  32'd6,   32'd7, 1'b1);
    idle_cycles(3);

    // Random ops, biased towards special divides and small divisors
    for (int i = 0; i < 60; i++) begin
      m_op_e       op;
      logic [31:0] a, b;
      int unsigned r;
      bit          drop;
      op   = m_op_e'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      r    = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = $urandom_range(1, 15);
      if (r == 3) b = -$urandom_range(1, 15);
      drop = ($urandom_range(0, 1) == 1);
      run_op(op, a, b, drop);
      if (drop) idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(5);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
